// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with valid/ready handshakes on both the enqueue and
// dequeue sides. It holds 2**PTR_WIDTH entries of DATA_WIDTH bits. The read
// and write pointers are wrap-around counters. An explicit occupancy counter
// drives the full/empty flags, so a full FIFO and an empty FIFO never look
// alike even though their pointers are equal in both cases.
//
// Ports
//   clk           in   clock; all state updates on the rising edge
//   reset         in   synchronous, active-high; clears pointers and occupancy
//   i__enq_valid  in   producer offers i__enq_data this cycle
//   i__enq_data   in   entry to write (DATA_WIDTH)
//   o__enq_ready  out  FIFO can accept an entry (not full)
//   o__deq_valid  out  o__deq_data holds the oldest entry (not empty)
//   o__deq_data   out  oldest entry, read combinationally from the head slot
//   i__deq_ready  in   consumer takes the head entry this cycle
//   o__occupancy  out  number of stored entries, 0..DEPTH (PTR_WIDTH+1 bits)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i__enq_valid,
    input  logic [DATA_WIDTH-1:0] i__enq_data,
    output logic                  o__enq_ready,
    output logic                  o__deq_valid,
    output logic [DATA_WIDTH-1:0] o__deq_data,
    input  logic                  i__deq_ready,
    output logic [PTR_WIDTH:0]    o__occupancy
);

    localparam int                   DEPTH      = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH-1:0] LAST_PTR   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);

    // Storage is deliberately not reset. Stale slots are never visible,
    // because o__deq_valid gates the read side.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [PTR_WIDTH:0]    r_occupancy;

    logic                  w_enq_ready;
    logic                  w_deq_valid;
    logic                  w_enq_fire;
    logic                  w_deq_fire;
    logic [PTR_WIDTH-1:0]  w_wr_ptr_next;
    logic [PTR_WIDTH-1:0]  w_rd_ptr_next;
    logic [PTR_WIDTH:0]    w_occupancy_next;

    // The flags depend only on registered occupancy. No input reaches them
    // combinationally, so a full FIFO refuses an enqueue even when a dequeue
    // fires in the same cycle.
    assign w_enq_ready = (r_occupancy != FULL_COUNT);
    assign w_deq_valid = (r_occupancy != '0);

    assign w_enq_fire  = i__enq_valid & w_enq_ready;
    assign w_deq_fire  = w_deq_valid & i__deq_ready;

    // The wrap is written out explicitly. This keeps the pointers correct
    // even if DEPTH is ever changed to a non-power-of-two value.
    assign w_wr_ptr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;
    assign w_rd_ptr_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;

    always_comb begin
        w_occupancy_next = r_occupancy;
        case ({w_enq_fire, w_deq_fire})
            2'b10:   w_occupancy_next = r_occupancy + COUNT_ONE;
            2'b01:   w_occupancy_next = r_occupancy - COUNT_ONE;
            default: w_occupancy_next = r_occupancy;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_deq_fire) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_occupancy <= w_occupancy_next;
        end
    end

    // The memory write is kept outside the reset branch. This lets the array
    // map onto distributed RAM. A write in a reset cycle is harmless: the
    // slot becomes unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= i__enq_data;
        end
    end

    assign o__enq_ready = w_enq_ready;
    assign o__deq_valid = w_deq_valid;
    assign o__deq_data  = r_mem[r_rd_ptr];
    assign o__occupancy = r_occupancy;

endmodule
